// File: rtl/serpent_fp_stage.sv
// Serpent output permutation stage: applies FP (or IP when i_dir=1) on the write path
// and buffers permuted beats in a 2-entry valid/ready FIFO carrying a sideband tag.
module serpent_fp_stage #(
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [127:0]     i_data,
    input  logic             i_dir,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [127:0]     o_data,
    output logic [TAG_W-1:0] o_tag,
    output logic [1:0]       o_count
);

    generate
        if (DEPTH != 2) begin : g_depth_check
            $error("serpent_fp_stage: DEPTH must be 2");
        end
    endgenerate

    function automatic logic [127:0] perm_ip(input logic [127:0] din);
        logic [127:0] dout;
        dout = '0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 32; k++) begin
                dout[127 - 4*k - j] = din[k + 32*j];
            end
        end
        return dout;
    endfunction

    function automatic logic [127:0] perm_fp(input logic [127:0] din);
        logic [127:0] dout;
        dout = '0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 32; k++) begin
                dout[32*j + k] = din[127 - 4*k - j];
            end
        end
        return dout;
    endfunction

    logic [127:0]     mem_r [0:1];
    logic [TAG_W-1:0] tag_mem_r [0:1];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             ready_r;

    logic             push_s;
    logic             pop_s;
    logic [1:0]       count_nxt_s;
    logic [127:0]     perm_s;

    // Handshake decode, occupancy update and write-path permutation select
    always_comb begin
        push_s      = i_valid && ready_r;
        pop_s       = (count_r != 2'd0) && i_ready;
        count_nxt_s = count_r;
        perm_s      = '0;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
        if (i_dir) begin
            perm_s = perm_ip(i_data);
        end else begin
            perm_s = perm_fp(i_data);
        end
    end

    // FIFO storage, pointers, occupancy and registered ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i]     <= '0;
                tag_mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r]     <= perm_s;
                tag_mem_r[wr_ptr_r] <= i_tag;
                wr_ptr_r            <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
            // ready looks at the post-update occupancy, so i_ready never reaches o_ready combinationally
            ready_r <= (count_nxt_s < 2'd2);
        end
    end

    assign o_ready = ready_r;
    assign o_valid = (count_r != 2'd0);
    assign o_data  = mem_r[rd_ptr_r];
    assign o_tag   = tag_mem_r[rd_ptr_r];
    assign o_count = count_r;

endmodule

// File: tb/tb_serpent_fp_stage.sv
// Bench for serpent_fp_stage: vector table, throughput, back-pressure, reset and
// IP/FP round trip, all checked through a scoreboard queue.
module tb_serpent_fp_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         ready;
    logic [127:0] in_data = '0;
    logic         dir = 1'b0;
    logic [3:0]   tag = 4'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [3:0]   out_tag;
    logic [1:0]   count;

    serpent_fp_stage #(.TAG_W(4), .DEPTH(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid), .o_ready(ready),
        .i_data(in_data), .i_dir(dir), .i_tag(tag), .o_valid(out_valid),
        .i_ready(out_ready), .o_data(out_data), .o_tag(out_tag), .o_count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] d; logic [3:0] t; } sb_t;
    typedef struct { logic dir; logic [127:0] data; logic [3:0] tag; logic [127:0] exp; } vec_t;

    sb_t          sbq[$];
    logic [127:0] cap[$];
    logic [127:0] orig[1000];
    logic [127:0] ip_out[1000];
    vec_t         vecs[8];
    int           checks = 0;
    int           fails = 0;
    logic         exp_ready = 1'b0;
    logic         acc = 1'b0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic [3:0]   prev_tag = 4'd0;
    logic         rand_rdy = 1'b0;
    logic [127:0] cur_exp = '0;
    logic [127:0] ones;
    logic [127:0] one;

    // Reference permutations written output-indexed, inverting the index map per bit
    function automatic logic [127:0] model_fp(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 128; i++) y[i] = x[127 - 4*(i % 32) - (i / 32)];
        return y;
    endfunction

    function automatic logic [127:0] model_ip(input logic [127:0] x);
        logic [127:0] y;
        for (int p = 0; p < 128; p++) y[p] = x[(127 - p) / 4 + 32*((127 - p) % 4)];
        return y;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: sample/check at negedge, update scoreboard, advance to posedge+1
    task automatic step();
        sb_t e;
        @(negedge clk);
        check("count", 128'(count), 128'(sbq.size()));
        check("o_valid", 128'(out_valid), 128'(sbq.size() != 0));
        check("o_ready", 128'(ready), 128'(exp_ready));
        if (prev_stall) begin
            check("hold_data", out_data, prev_data);
            check("hold_tag", 128'(out_tag), 128'(prev_tag));
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_tag   = out_tag;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_out: got beat %h with empty scoreboard", out_data);
            end else begin
                e = sbq.pop_front();
                check("data", out_data, e.d);
                check("tag", 128'(out_tag), 128'(e.t));
                cap.push_back(out_data);
            end
        end
        acc = in_valid && ready;
        if (acc) sbq.push_back('{d: cur_exp, t: tag});
        @(posedge clk);
        #1;
        exp_ready = rst_n && (sbq.size() < 2);
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [127:0] d, input logic dr, input logic [3:0] t, input logic [127:0] e);
        in_valid = 1'b1; in_data = d; dir = dr; tag = t; cur_exp = e;
        for (int n = 0; n < 64; n++) begin
            step();
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: beat tag %0d not accepted", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (sbq.size() == 0) break;
            step();
        end
        check("drain_empty", 128'(sbq.size()), 128'(0));
    endtask

    initial begin
        ones = '1;
        one  = 128'd1;
        vecs[0] = '{dir: 1'b0, data: one << 127, tag: 4'd1, exp: one << 0};
        vecs[1] = '{dir: 1'b0, data: one << 126, tag: 4'd2, exp: one << 32};
        vecs[2] = '{dir: 1'b0, data: one << 0,   tag: 4'd3, exp: one << 127};
        vecs[3] = '{dir: 1'b1, data: one << 0,   tag: 4'd4, exp: one << 127};
        vecs[4] = '{dir: 1'b1, data: one << 127, tag: 4'd5, exp: one << 0};
        vecs[5] = '{dir: 1'b1, data: one << 32,  tag: 4'd6, exp: one << 126};
        vecs[6] = '{dir: 1'b0, data: ones,       tag: 4'd7, exp: ones};
        vecs[7] = '{dir: 1'b1, data: 128'd0,     tag: 4'd8, exp: 128'd0};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_ready", 128'(ready), 128'(0));
        check("rst_count", 128'(count), 128'(0));
        check("rst_data", out_data, 128'd0);
        check("rst_tag", 128'(out_tag), 128'(0));
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 128'(ready), 128'(1));

        // Vector table
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(vecs[i].data, vecs[i].dir, vecs[i].tag, vecs[i].exp);
        drain();

        // Full throughput, tags 0..15
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            dir = 1'b0; tag = 4'(i); cur_exp = model_fp(in_data);
            step();
            check("tp_accept", 128'(acc), 128'(1));
            check("tp_count", 128'(count), 128'(1));
            check("tp_ready", 128'(ready), 128'(1));
        end
        in_valid = 1'b0;
        drain();

        // Back-pressure with three beats A, B, C, then push/pop at full
        out_ready = 1'b0;
        send(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978, 1'b0, 4'hA, model_fp(128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978));
        send(128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0, 1'b1, 4'hB, model_ip(128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0));
        in_valid = 1'b1; in_data = 128'h5555_aaaa_3333_cccc_0f0f_f0f0_00ff_ff00; dir = 1'b0; tag = 4'hC;
        cur_exp = model_fp(in_data);
        for (int n = 0; n < 3; n++) begin
            step();
            check("bp_no_accept", 128'(acc), 128'(0));
            check("bp_count", 128'(count), 128'(2));
            check("bp_ready", 128'(ready), 128'(0));
        end
        out_ready = 1'b1;
        step();
        check("full_pop_no_accept", 128'(acc), 128'(0));
        out_ready = 1'b0;
        check("full_pop_count", 128'(count), 128'(1));
        check("full_pop_ready", 128'(ready), 128'(1));
        step();
        check("c_accept", 128'(acc), 128'(1));
        in_valid = 1'b0;
        step();
        step();
        drain();

        // Reset with two beats buffered
        out_ready = 1'b0;
        send(128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 4'h1, model_fp(128'h1111_2222_3333_4444_5555_6666_7777_8888));
        send(128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000, 1'b0, 4'h2, model_fp(128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000));
        check("pre_rst_count", 128'(count), 128'(2));
        rst_n = 1'b0;
        sbq.delete();
        exp_ready = 1'b0;
        prev_stall = 1'b0;
        #1;
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_ready", 128'(ready), 128'(0));
        check("mid_rst_count", 128'(count), 128'(0));
        check("mid_rst_data", out_data, 128'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_ready_rise", 128'(ready), 128'(1));
        out_ready = 1'b1;
        send(ones, 1'b0, 4'hF, ones);
        drain();

        // Round trip: IP then FP restores the originals in order
        for (int i = 0; i < 1000; i++) orig[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        cap.delete();
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) send(orig[i], 1'b1, 4'(i), model_ip(orig[i]));
        rand_rdy = 1'b0;
        drain();
        check("rt_ip_count", 128'(cap.size()), 128'(1000));
        for (int i = 0; i < 1000; i++) ip_out[i] = (i < cap.size()) ? cap[i] : 128'd0;
        cap.delete();
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) send(ip_out[i], 1'b0, 4'(i), orig[i]);
        rand_rdy = 1'b0;
        drain();
        check("rt_fp_count", 128'(cap.size()), 128'(1000));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/serpent_fp_stage.md
Name: serpent_fp_stage

Overview:
- Buffered, handshaked Serpent permutation stage placed at the cipher-core output.
- Applies the Final Permutation (FP), which is the exact inverse of the Initial Permutation (IP), to each 128-bit beat.
- A per-beat direction bit selects IP instead, so the same stage serves decrypt-side un-permutation.
- Contains a 2-entry output buffer with valid/ready on both sides: full throughput, 1-cycle latency, and a sideband tag carried alongside the data.

Parameters:
- TAG_W, 4, width of the sideband tag carried with each beat (block index / XTS lane).
- DEPTH, 2, buffer entries; fixed at 2, and any other value is a synthesis error.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  stage can accept a beat this cycle.
- i_data  in  128  input block.
- i_dir  in  1  0 = apply FP, 1 = apply IP.
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_data  out  128  permuted block.
- o_tag  out  TAG_W  tag of the beat on o_data.
- o_count  out  2  occupied entries (0..2).

Behaviour:
- Permutation definitions (indices are bit positions, 127 = MSB; j in 0..3, k in 0..31):
  - IP: out[127-4k-j] = in[k+32j].
  - FP: out[32j+k] = in[127-4k-j].
  - FP(IP(x)) = x and IP(FP(x)) = x for all x.
- The permutation is applied combinationally on the write path. The entry stores the already-permuted value, selected by i_dir sampled at acceptance.
- Accept condition: i_valid && o_ready at a rising edge.
- Drain condition: o_valid && i_ready at a rising edge.
- Storage is a 2-entry FIFO with a 1-bit write pointer, a 1-bit read pointer and a 2-bit count.
- o_valid = (count != 0). o_data and o_tag come from the head entry; all are driven from registers with no combinational path from i_data.
- o_ready is registered. Next value = (next_count < 2). No combinational path from i_ready to o_ready.
- Latency: a beat accepted at edge N is on o_data with o_valid = 1 after edge N; it can drain at edge N+1.
- Simultaneous push and pop:
  - count = 1: count stays 1, both pointers advance.
  - count = 0: push only, because o_valid = 0.
  - count = 2: pop only, because o_ready = 0; after the pop, count = 1 and o_ready = 1.
- Back-pressure: while i_ready = 0, the head entry and o_tag are held stable. o_valid must not drop once asserted until the beat drains.
- Ordering: strict FIFO. The tag always stays paired with its data.
- i_valid while o_ready = 0: the beat is ignored. The upstream holds its beat per standard valid/ready rules; no error is flagged.
- Reset (asynchronous assert, synchronous deassert handled by the system reset synchronizer):
  - o_valid = 0, o_ready = 0, o_count = 0, o_data = 0, o_tag = 0, pointers = 0.
  - o_ready rises at the first rising edge after deassertion.
- Reset mid-operation: all buffered beats are discarded; no partial beat survives.
- No X propagation: unused storage entries reset to 0.

Test Plan:
- IP/FP vectors:
  - i_dir = 0, i_data = 1<<127 → o_data = 1<<0.
  - i_data = 1<<126 → o_data = 1<<32.
  - i_data = 1<<0 → o_data = 1<<127.
  - i_dir = 1, i_data = 1<<0 → o_data = 1<<127.
- Round trip: 1000 random blocks are sent with i_dir = 1, and the results are looped back with i_dir = 0 → final output equals the originals, with tags in order.
- Full throughput: i_valid = 1 and i_ready = 1 held for 16 beats with tags 0..15 → one output per cycle starting the cycle after the first accept, o_count = 1 steady, o_ready never drops.
- Back-pressure: i_ready = 0, send 3 beats →
  - o_count reaches 2 and o_ready = 0; the third beat is not accepted and is held by the source.
  - After i_ready = 1, outputs appear in order A, B, C with o_data stable during the stall.
- Push/pop at full: with count = 2, assert i_ready for one cycle → count = 1 and o_ready = 1 on the next cycle, with no beat lost or duplicated.
- Reset mid-stream: assert i_rst_n = 0 with 2 beats buffered →
  - o_valid, o_ready, o_count and o_data go to 0 immediately.
  - After release, o_ready rises one edge later, and a fresh beat of 0xFFFF…FF with i_dir = 0 produces 0xFFFF…FF.
